gate_bist: RTL and testbench
============================

# gate_bist

Built-in self-test sequencer for the lab's 2-input gate modules. It drives the full exhaustive input sweep into a device under test, samples its output after a programmable settle time, and compares each sample against a selectable reference truth table. It reports per-vector mismatches and pass/fail. It replaces a printed truth table with a synthesizable checker on the stimulus/response side of the gate.

## Interface
Parameters:
- SETTLE_CYCLES, 2: clock cycles each vector is held before `dut_y` is sampled. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a test run; sampled only when idle.
- func  in  3  reference function, latched on start accept:
  - 000 AND, 001 OR, 010 XOR, 011 NAND
  - 100 NOR, 101 XNOR, 110 BUF(a), 111 NOT(a)
- dut_a  out  1  stimulus to the DUT input a.
- dut_b  out  1  stimulus to the DUT input b.
- dut_y  in  1  DUT output under test.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  1 when the last completed run had zero mismatches.
- fail_mask  out  4  bit i set if vector i mismatched, where i = {dut_a, dut_b}.
- err_count  out  3  number of mismatching vectors, 0..4.

## Operation
- Vectors are applied in order i = 0,1,2,3, i.e. {a,b} = 00, 01, 10, 11.
- FSM states:
  - IDLE: wait for start.
  - RUN: an internal settle counter (4 bits) and a vector index (2 bits) advance.
- IDLE -> RUN on start=1:
  - latch func
  - clear fail_mask, err_count and pass
  - drive vector 0
  - load counter with SETTLE_CYCLES
- RUN, counter > 1: decrement the counter.
- RUN, counter == 1 (sample edge):
  - Compare dut_y with ref(func, a, b).
  - On mismatch, set fail_mask[i] and increment err_count.
  - If i < 3, drive vector i+1 and reload the counter.
  - If i == 3, go to IDLE, pulse done, set pass = (total mismatches == 0), and hold dut_a/dut_b at 11.
- A mismatch is any dut_y not equal to the expected bit. In simulation, X/Z on dut_y counts as a mismatch.
- start while busy is ignored; the latched func is unaffected by later changes.
- fail_mask, err_count and pass hold their values after done until the next accepted start.

## Timing
- Reset values (asynchronous, immediate): dut_a=0, dut_b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, FSM=IDLE.
- Start accepted at edge E0. Busy is high from E0 until edge E(4·S), where S = SETTLE_CYCLES.
- Vector i is driven from edge E(i·S) and sampled at edge E((i+1)·S).
- Done is high for exactly the one cycle following E(4·S). Busy is 0 in that same cycle.
- Latency from start accept to the done cycle is 4·S cycles; with S=2 this is 8.
- Back-to-back runs: start=1 during the done cycle is accepted, giving a new E0 at the next edge. Results are cleared at that edge.
- Reset asserted mid-run aborts immediately: outputs return to reset values and no done pulse is generated.
- Start held continuously high produces back-to-back runs with a gap of exactly one idle (done) cycle.

## Test plan
- **Reset:** assert rst for 3 cycles with start=1.
  - During reset, all outputs are 0 and busy stays 0.
  - After release, a run starts on the first edge with start=1.
- **OR pass (func=001, S=2):** connect dut_y to a | b.
  - Observe 00, 01, 10, 11, each held 2 cycles.
  - done is seen 8 cycles after start; pass=1, fail_mask=0000, err_count=0.
- **Wrong function (func=000, AND):** connect dut_y to a | b.
  - Expect fail_mask=0110, err_count=2, pass=0.
- **Stuck-at faults:**
  - dut_y tied 0 with func=001: fail_mask=1110, err_count=3.
  - dut_y tied 1 with func=101 (XNOR): fail_mask=0110, err_count=2.
  - dut_y tied 1 with func=111 (NOT a): fail_mask=1100.
- **Handshake:**
  - Pulse start again mid-run and change func mid-run: no effect on the run.
  - Start in the done cycle restarts: busy returns on the next edge and results clear.
  - func=110 with dut_y=a: pass=1.
- **Reset mid-run:** assert rst at cycle 5 of an S=2 run.
  - Outputs are 0 immediately and no done pulse occurs.
  - A subsequent start completes a full run with correct results.

Source files
------------

// File: rtl/gate_bist_if.sv
// Stimulus/response bundle between the gate BIST sequencer and its driver.
// The master side owns start/func and plays the gate under test (dut_y).
interface gate_bist_if;
    logic       start;
    logic [2:0] func;
    logic       dut_a;
    logic       dut_b;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;

    modport master (
        output start, func, dut_y,
        input  dut_a, dut_b, busy, done,
        input  pass, fail_mask, err_count
    );

    modport slave (
        input  start, func, dut_y,
        output dut_a, dut_b, busy, done,
        output pass, fail_mask, err_count
    );
endinterface

// File: rtl/gate_bist.sv
// Exhaustive 2-input gate checker: sweeps {a,b}=00..11, samples dut_y
// after SETTLE_CYCLES and compares it with a selectable truth table.
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    gate_bist_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] idx;
    logic [2:0] fn;
    logic       exp_y;
    logic       miss;

    function automatic logic ref_y(
        input logic [2:0] f,
        input logic       a,
        input logic       b
    );
        case (f)
            3'b000:  ref_y = a & b;
            3'b001:  ref_y = a | b;
            3'b010:  ref_y = a ^ b;
            3'b011:  ref_y = ~(a & b);
            3'b100:  ref_y = ~(a | b);
            3'b101:  ref_y = ~(a ^ b);
            3'b110:  ref_y = a;
            default: ref_y = ~a;
        endcase
    endfunction

    // Case inequality so an undriven or X output counts as a mismatch.
    always_comb begin
        exp_y = ref_y(fn, bus.dut_a, bus.dut_b);
        miss  = (bus.dut_y !== exp_y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            fn            <= '0;
            bus.dut_a     <= 1'b0;
            bus.dut_b     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.fail_mask <= '0;
            bus.err_count <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= RUN;
                        fn            <= bus.func;
                        cnt           <= SETTLE;
                        idx           <= '0;
                        bus.dut_a     <= 1'b0;
                        bus.dut_b     <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.pass      <= 1'b0;
                        bus.fail_mask <= '0;
                        bus.err_count <= '0;
                    end
                end
                RUN: begin
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (miss) begin
                            bus.fail_mask[idx] <= 1'b1;
                            bus.err_count      <= bus.err_count + 3'd1;
                        end
                        if (idx != 2'd3) begin
                            idx                    <= idx + 2'd1;
                            {bus.dut_a, bus.dut_b} <= idx + 2'd1;
                            cnt                    <= SETTLE;
                        end else begin
                            // Vector 11 stays applied after the run ends.
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (bus.err_count == 3'd0) && !miss;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gate_bist.sv
// Directed and randomized checks of gate_bist against a truth-table model.
// The bench plays the gate under test through a 4-entry response table.
module tb_gate_bist;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] tt  = 4'b0000;
    int         checks   = 0;
    int         failures = 0;

    gate_bist_if bus ();

    gate_bist #(.SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.dut_y = tt[{bus.dut_a, bus.dut_b}];

    function automatic logic [3:0] ref_table(input logic [2:0] f);
        logic [3:0] t;
        int a, b;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            a = i / 2;
            b = i % 2;
            case (f)
                3'd0:    t[i] = ((a * b) == 1);
                3'd1:    t[i] = ((a + b) > 0);
                3'd2:    t[i] = ((a + b) == 1);
                3'd3:    t[i] = ((a * b) == 0);
                3'd4:    t[i] = ((a + b) == 0);
                3'd5:    t[i] = (a == b);
                3'd6:    t[i] = (a == 1);
                default: t[i] = (a == 0);
            endcase
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"},    8'(bus.dut_a), 8'd0);
        check({tag, "_b"},    8'(bus.dut_b), 8'd0);
        check({tag, "_busy"}, 8'(bus.busy), 8'd0);
        check({tag, "_done"}, 8'(bus.done), 8'd0);
        check({tag, "_pass"}, 8'(bus.pass), 8'd0);
        check({tag, "_mask"}, 8'(bus.fail_mask), 8'd0);
        check({tag, "_err"},  8'(bus.err_count), 8'd0);
    endtask

    // One full run; the accept edge is the next clock edge.
    task automatic run(input logic [2:0] f, input logic [3:0] resp,
                       input bit disturb);
        logic [3:0] em;
        int         ec;
        em = resp ^ ref_table(f);
        ec = $countones(em);
        bus.func  = f;
        tt        = resp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("clr_mask", 8'(bus.fail_mask), 8'd0);
        check("clr_err",  8'(bus.err_count), 8'd0);
        check("clr_pass", 8'(bus.pass), 8'd0);
        for (int k = 0; k < 4 * S; k++) begin
            if (k > 0) tick();
            check("run_busy", 8'(bus.busy), 8'd1);
            check("run_done", 8'(bus.done), 8'd0);
            check("run_vec", 8'({bus.dut_a, bus.dut_b}), 8'(k / S));
            if (disturb && k == 3) begin
                bus.start = 1'b1;
                bus.func  = ~f;
            end
            if (disturb && k == 4) bus.start = 1'b0;
        end
        tick();
        check("end_done", 8'(bus.done), 8'd1);
        check("end_busy", 8'(bus.busy), 8'd0);
        check("end_vec",  8'({bus.dut_a, bus.dut_b}), 8'd3);
        check("end_mask", 8'(bus.fail_mask), 8'(em));
        check("end_err",  8'(bus.err_count), 8'(ec));
        check("end_pass", 8'(bus.pass), 8'(ec == 0));
    endtask

    task automatic idle_hold(input logic [3:0] em);
        tick();
        check("hold_done", 8'(bus.done), 8'd0);
        check("hold_busy", 8'(bus.busy), 8'd0);
        check("hold_mask", 8'(bus.fail_mask), 8'(em));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rf;
        logic [3:0] rt;
        bus.start = 1'b0;
        bus.func  = 3'b000;

        rst       = 1'b1;
        bus.start = 1'b1;
        bus.func  = 3'b001;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero("rst");
        end
        rst = 1'b0;

        run(3'b001, 4'b1110, 1'b0);
        idle_hold(4'b0000);
        run(3'b000, 4'b1110, 1'b0);
        check("and_vs_or_mask", 8'(bus.fail_mask), 8'b0110);
        idle_hold(4'b0110);
        run(3'b001, 4'b0000, 1'b0);
        check("stuck0_mask", 8'(bus.fail_mask), 8'b1110);
        idle_hold(4'b1110);
        run(3'b101, 4'b1111, 1'b0);
        check("stuck1_xnor", 8'(bus.fail_mask), 8'b0110);
        idle_hold(4'b0110);
        run(3'b111, 4'b1111, 1'b0);
        check("stuck1_nota", 8'(bus.fail_mask), 8'b1100);
        idle_hold(4'b1100);

        run(3'b001, 4'b1110, 1'b1);
        run(3'b000, 4'b0000, 1'b0);
        run(3'b110, 4'b1100, 1'b0);
        idle_hold(4'b0000);

        bus.func  = 3'b001;
        tt        = 4'b1110;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check_zero("midrst");
        for (int i = 0; i < 2; i++) begin
            tick();
            check("midrst_done", 8'(bus.done), 8'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post_rst_done", 8'(bus.done), 8'd0);
            check("post_rst_busy", 8'(bus.busy), 8'd0);
        end
        run(3'b010, 4'b0110, 1'b0);

        for (int r = 0; r < 12; r++) begin
            rf = 3'($urandom_range(0, 7));
            rt = 4'($urandom_range(0, 15));
            run(rf, rt, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_hold(rt ^ ref_table(rf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
